// File: rtl/r32_mem_tester_if.sv
// R32 memory bus: request channel (master -> memory) and in-order read response channel.
interface r32_mem_tester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_data;
    logic              m_write;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output m_address, m_data, m_write, m_valid, s_ready,
        input  m_ready, s_data, s_valid
    );

    modport slave (
        input  m_address, m_data, m_write, m_valid, s_ready,
        output m_ready, s_data, s_valid
    );
endinterface

// File: rtl/r32_mem_tester.sv
// Memory pattern-test engine: writes a generated pattern over a range, reads it back,
// counts mismatches and records the first failing address.
module r32_mem_tester #(
    parameter int               ADDR_W  = 32,
    parameter int               DATA_W  = 32,
    parameter int               CNT_W   = 16,
    parameter int               MAX_OUT = 4,
    parameter logic [DATA_W-1:0] PATTERN = {DATA_W/2{2'b10}},
    parameter int               ERR_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    r32_mem_tester_if.master    bus,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]    count_i,
    input  logic [1:0]          mode_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ERR_W-1:0]    err_count_o,
    output logic [ADDR_W-1:0]   first_err_addr_o
);
    localparam int STRIDE = DATA_W / 8;
    localparam int OUT_W  = 4;
    localparam logic [DATA_W-1:0] ONE_BIT = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   issue_idx_q, issue_idx_d;
    logic [CNT_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic               m_valid_q, m_valid_d;
    logic               m_write_q, m_write_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               s_ready_q, s_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0]  cmp_data_q, cmp_data_d;
    logic [CNT_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ADDR_W-1:0]  first_q, first_d;

    logic               req_acc_s, rsp_acc_s, mismatch_s, can_issue_s;
    logic [ADDR_W-1:0]  cmp_addr_s, issue_addr_s;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(STRIDE);
    endfunction

    // Mode 1 uses the byte address of the word itself as the data.
    function automatic logic [DATA_W-1:0] pat_f(input logic [1:0]        mode,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [CNT_W-1:0]  idx);
        logic [CNT_W-1:0] sh;
        sh = idx % CNT_W'(DATA_W);
        case (mode)
            2'd0:    return PATTERN;
            2'd1:    return DATA_W'(addr);
            2'd2:    return idx[0] ? ~PATTERN : PATTERN;
            2'd3:    return ONE_BIT << sh;
            default: return PATTERN;
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            mode_q      <= 2'd0;
            issue_idx_q <= '0;
            rsp_idx_q   <= '0;
            outst_q     <= '0;
            m_valid_q   <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_data_q  <= '0;
            cmp_idx_q   <= '0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            issue_idx_q <= issue_idx_d;
            rsp_idx_q   <= rsp_idx_d;
            outst_q     <= outst_d;
            m_valid_q   <= m_valid_d;
            m_write_q   <= m_write_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_data_q  <= cmp_data_d;
            cmp_idx_q   <= cmp_idx_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    // Next-state, request issue, response capture and compare.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        mode_d      = mode_q;
        issue_idx_d = issue_idx_q;
        rsp_idx_d   = rsp_idx_q;
        m_valid_d   = m_valid_q;
        m_write_d   = m_write_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        cmp_valid_d = 1'b0;
        cmp_data_d  = cmp_data_q;
        cmp_idx_d   = cmp_idx_q;

        req_acc_s    = m_valid_q && bus.m_ready;
        rsp_acc_s    = s_ready_q && bus.s_valid;
        outst_d      = outst_q + OUT_W'(req_acc_s && !m_write_q) - OUT_W'(rsp_acc_s);
        cmp_addr_s   = addr_of(base_q, cmp_idx_q);
        mismatch_s   = cmp_valid_q && (cmp_data_q != pat_f(mode_q, cmp_addr_s, cmp_idx_q));
        err_d        = (mismatch_s && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
        first_d      = (mismatch_s && (err_q == '0)) ? cmp_addr_s : first_q;
        issue_addr_s = addr_of(base_q, issue_idx_q);
        // Using outst_d lets a same-cycle response free a slot, so valid never rises at the limit.
        can_issue_s  = (issue_idx_q != count_q) &&
                       ((state_q == S_WRITE) || (outst_d < OUT_W'(MAX_OUT)));

        if (rsp_acc_s) begin
            cmp_valid_d = 1'b1;
            cmp_data_d  = bus.s_data;
            cmp_idx_d   = rsp_idx_q;
            rsp_idx_d   = rsp_idx_q + CNT_W'(1);
        end else begin
            cmp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d      = base_addr_i;
                    count_d     = count_i;
                    mode_d      = mode_i;
                    issue_idx_d = '0;
                    rsp_idx_d   = '0;
                    err_d       = '0;
                    first_d     = '0;
                    state_d     = (count_i == '0) ? S_DONE : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE, S_READ: begin
                if (!m_valid_q || req_acc_s) begin
                    if (can_issue_s) begin
                        m_valid_d   = 1'b1;
                        m_write_d   = (state_q == S_WRITE);
                        m_addr_d    = issue_addr_s;
                        m_data_d    = (state_q == S_WRITE) ?
                                      pat_f(mode_q, issue_addr_s, issue_idx_q) : '0;
                        issue_idx_d = issue_idx_q + CNT_W'(1);
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end else begin
                    m_valid_d = m_valid_q;
                end
                if (req_acc_s && (issue_idx_q == count_q)) begin
                    state_d     = (state_q == S_WRITE) ? S_READ : S_DRAIN;
                    issue_idx_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: state_d = (outst_q == '0) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        s_ready_d = (state_d == S_READ) || (state_d == S_DRAIN);
    end

    assign bus.m_address     = m_addr_q;
    assign bus.m_data        = m_data_q;
    assign bus.m_write       = m_write_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.s_ready       = s_ready_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_count_o       = err_q;
    assign first_err_addr_o  = first_q;
endmodule

// File: tb/tb_r32_mem_tester.sv
// Scoreboard bench for r32_mem_tester: echo memory slave, beat/result queues, bus monitor.
module tb_r32_mem_tester;
    localparam int MAXO = 4;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct { logic [15:0] err; logic [31:0] first; } res_t;
    typedef struct { logic [31:0] addr; int rdy; } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = 32'h0;
    logic [15:0] cnt = 16'h0;
    logic [1:0]  mode = 2'd0;
    logic        busy, done;
    logic [15:0] errc;
    logic [31:0] ferr;

    r32_mem_tester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    r32_mem_tester #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_OUT(MAXO), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .start_i(start), .base_addr_i(base), .count_i(cnt), .mode_i(mode),
        .busy_o(busy), .done_o(done), .err_count_o(errc), .first_err_addr_o(ferr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    beat_t exp_beats[$];
    res_t  exp_res[$];
    pend_t pend[$];
    logic [31:0] mem [logic [31:0]];
    int  rsp_delay = 0;
    bit  rand_ready = 1'b0;
    bit  corrupt_one = 1'b0;
    bit  corrupt_all = 1'b0;
    logic [31:0] corrupt_addr = 32'h0;
    bit  flush = 1'b0;
    int  mon_out = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] bench_pat(input logic [1:0] md, input logic [31:0] a, input int i);
        case (md)
            2'd0:    return 32'hAAAA_AAAA;
            2'd1:    return a;
            2'd2:    return (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            2'd3:    return 32'h1 << (i % 32);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (corrupt_all || (corrupt_one && a == corrupt_addr)) return 32'h0;
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory slave: drives ready/response on the falling edge, books handshakes just after.
    always @(negedge clk) begin
        if (flush) pend.delete();
        bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0].rdy <= cyc) begin
            bus.s_valid = 1'b1;
            bus.s_data  = mem_rd(pend[0].addr);
        end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = 32'h0;
        end
        #1;
        if (!rst) begin
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_write) mem[bus.m_address] = bus.m_data;
                else pend.push_back('{bus.m_address, cyc + rsp_delay});
            end
            if (bus.s_valid && bus.s_ready) void'(pend.pop_front());
        end
    end

    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic        prev_wr;

    // Monitor: pops expected beats/results as the DUT presents them.
    always @(negedge clk) begin
        beat_t e;
        res_t  r;
        #2;
        if (rst) begin
            prev_hold = 1'b0;
            mon_out   = 0;
        end else begin
            if (prev_hold)
                chk("req_stable", {bus.m_valid, bus.m_write, bus.m_address, bus.m_data[30:0]},
                    {1'b1, prev_wr, prev_addr, prev_data[30:0]});
            if (bus.m_valid && !bus.m_write)
                chk("read_below_max_out", 64'(mon_out < MAXO), 64'd1);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", {bus.m_write, bus.m_address}, 64'h0);
                end else begin
                    e = exp_beats.pop_front();
                    chk("beat_wr_addr", {bus.m_write, bus.m_address}, {e.wr, e.addr});
                    if (e.wr) chk("beat_wdata", bus.m_data, e.data);
                end
                if (!bus.m_write) mon_out++;
            end
            if (bus.s_valid && bus.s_ready) mon_out--;
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_addr = bus.m_address;
            prev_data = bus.m_data;
            prev_wr   = bus.m_write;
            if (done) begin
                done_cnt++;
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    r = exp_res.pop_front();
                    chk("err_count", errc, r.err);
                    if (r.err != 16'h0) chk("first_err_addr", ferr, r.first);
                end
            end
        end
    end

    task automatic queue_test(input logic [31:0] b, input logic [15:0] n, input logic [1:0] md,
                              input logic [15:0] e_err, input logic [31:0] e_first);
        for (int i = 0; i < int'(n); i++)
            exp_beats.push_back('{1'b1, b + 32'(4 * i), bench_pat(md, b + 32'(4 * i), i)});
        for (int i = 0; i < int'(n); i++)
            exp_beats.push_back('{1'b0, b + 32'(4 * i), 32'h0});
        exp_res.push_back('{e_err, e_first});
        @(negedge clk);
        start = 1'b1; base = b; cnt = n; mode = md;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_test(input logic [31:0] b, input logic [15:0] n, input logic [1:0] md,
                            input logic [15:0] e_err, input logic [31:0] e_first,
                            input int budget, input bit extra_start);
        int d0;
        bit seen;
        d0 = done_cnt;
        queue_test(b, n, md, e_err, e_first);
        if (extra_start) begin
            @(negedge clk);
            start = 1'b1; base = 32'h5000; cnt = 16'd5; mode = 2'd3;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk); #3;
            seen = (done_cnt != d0);
        end
        chk("done_within_budget", 64'(seen), 64'd1);
        if (seen) begin
            @(negedge clk); #3;
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        chk({tag, "_m_write"}, 64'(bus.m_write), 64'd0);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_addr_data"}, {bus.m_address, bus.m_data}, 64'h0);
        chk({tag, "_err_first"}, {errc, ferr}, 64'h0);
    endtask

    initial begin
        bit reached;
        repeat (3) @(negedge clk);
        #3;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // 1: base 0x100, 4 words of 0xAAAAAAAA, clean echo.
        run_test(32'h100, 16'd4, 2'd0, 16'd0, 32'h0, 200, 1'b0);
        // 2: alternating pattern, word 1 corrupted.
        corrupt_one = 1'b1; corrupt_addr = 32'h204;
        run_test(32'h200, 16'd3, 2'd2, 16'd1, 32'h204, 200, 1'b0);
        corrupt_one = 1'b0;
        // every word corrupted: count all, first is base.
        corrupt_all = 1'b1;
        run_test(32'h240, 16'd3, 2'd1, 16'd3, 32'h240, 200, 1'b0);
        corrupt_all = 1'b0;
        // 3: walking one, slow responses, outstanding limit.
        rsp_delay = 10;
        run_test(32'h1000, 16'd8, 2'd3, 16'd0, 32'h0, 400, 1'b0);
        rsp_delay = 0;
        // 4: random m_ready, address-as-data wrapping through zero.
        rand_ready = 1'b1;
        run_test(32'hFFFF_FFF8, 16'd6, 2'd1, 16'd0, 32'h0, 400, 1'b0);
        rand_ready = 1'b0;
        // 5: empty test, then a start while busy.
        run_test(32'h700, 16'd0, 2'd0, 16'd0, 32'h0, 2, 1'b0);
        run_test(32'h300, 16'd2, 2'd0, 16'd0, 32'h0, 200, 1'b1);

        // 6: reset in READ with two reads outstanding.
        rsp_delay = 10;
        queue_test(32'h600, 16'd8, 2'd0, 16'd0, 32'h0);
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            @(negedge clk); #3;
            reached = (mon_out == 2);
        end
        chk("reached_two_outstanding", 64'(reached), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midtest_reset");
        exp_beats.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #3;
            chk("late_rsp_s_ready", 64'(bus.s_ready), 64'd0);
        end
        flush = 1'b1;
        @(negedge clk); #3;
        flush = 1'b0;
        rsp_delay = 0;
        run_test(32'h400, 16'd2, 2'd2, 16'd0, 32'h0, 200, 1'b0);

        chk("beats_left", 64'(exp_beats.size()), 64'd0);
        chk("results_left", 64'(exp_res.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
